// File: rtl/iq_sweep_pkg.sv
// Shared types and defaults for the DDS phase-increment sweep controller.
package iq_sweep_pkg;

    localparam int unsigned DEF_PHASE_W = 16;
    localparam int unsigned DEF_DWELL_W = 24;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DWELL  = 2'd1,
        STEP   = 2'd2,
        FINISH = 2'd3
    } sweep_state_t;

    typedef enum logic {
        UP   = 1'b0,
        DOWN = 1'b1
    } sweep_dir_t;

endpackage

// File: rtl/sweep_next_inc.sv
// Next phase increment, clamped to the stop value; a zero step jumps straight to stop.
module sweep_next_inc
    import iq_sweep_pkg::*;
#(
    parameter int unsigned W = DEF_PHASE_W
) (
    input  logic [W-1:0] cur,
    input  logic [W-1:0] step,
    input  logic [W-1:0] stop,
    input  sweep_dir_t   dir,
    output logic [W-1:0] next_inc_c
);

    logic [W:0] sum;
    logic [W:0] diff;

    // One extra bit so overflow and underflow are seen instead of wrapping.
    always_comb begin
        sum        = {1'b0, cur} + {1'b0, step};
        diff       = {1'b0, cur} - {1'b0, step};
        next_inc_c = stop;
        if (step != '0) begin
            if (dir == UP) begin
                if (sum <= {1'b0, stop}) next_inc_c = sum[W-1:0];
            end else begin
                if (!diff[W] && (diff[W-1:0] >= stop)) next_inc_c = diff[W-1:0];
            end
        end
    end

endmodule

// File: rtl/iq_freq_sweep_ctrl.sv
// Sweep/hop controller producing the DDS phase increment: start to stop in
// clamped steps, each value held for a programmable dwell, single pass or repeating.
module iq_freq_sweep_ctrl
    import iq_sweep_pkg::*;
#(
    parameter int unsigned PHASE_W = DEF_PHASE_W,
    parameter int unsigned DWELL_W = DEF_DWELL_W
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [PHASE_W-1:0] cfg_start_inc,
    input  logic [PHASE_W-1:0] cfg_stop_inc,
    input  logic [PHASE_W-1:0] cfg_step,
    input  logic [DWELL_W-1:0] cfg_dwell,
    input  logic               cfg_repeat,
    input  logic               start,
    input  logic               abort,
    output logic [PHASE_W-1:0] dds_phase_inc,
    output logic               inc_valid,
    output logic               busy,
    output logic               done
);

    sweep_state_t       state_q, state_d;
    sweep_dir_t         dir_q, dir_d;
    logic [PHASE_W-1:0] start_q, start_d;
    logic [PHASE_W-1:0] stop_q, stop_d;
    logic [PHASE_W-1:0] step_q, step_d;
    logic [DWELL_W-1:0] reload_q, reload_d;
    logic [DWELL_W-1:0] cnt_q, cnt_d;
    logic               repeat_q, repeat_d;
    logic               wrap_q, wrap_d;
    logic [PHASE_W-1:0] inc_d;
    logic               inc_valid_d, busy_d, done_d;
    logic [PHASE_W-1:0] next_inc_c;
    logic [PHASE_W-1:0] step_val_c;

    sweep_next_inc #(.W(PHASE_W)) u_next (
        .cur        (dds_phase_inc),
        .step       (step_q),
        .stop       (stop_q),
        .dir        (dir_q),
        .next_inc_c (next_inc_c)
    );

    assign step_val_c = wrap_q ? start_q : next_inc_c;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            dir_q         <= UP;
            start_q       <= '0;
            stop_q        <= '0;
            step_q        <= '0;
            reload_q      <= '0;
            cnt_q         <= '0;
            repeat_q      <= 1'b0;
            wrap_q        <= 1'b0;
            dds_phase_inc <= '0;
            inc_valid     <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
        end else begin
            state_q       <= state_d;
            dir_q         <= dir_d;
            start_q       <= start_d;
            stop_q        <= stop_d;
            step_q        <= step_d;
            reload_q      <= reload_d;
            cnt_q         <= cnt_d;
            repeat_q      <= repeat_d;
            wrap_q        <= wrap_d;
            dds_phase_inc <= inc_d;
            inc_valid     <= inc_valid_d;
            busy          <= busy_d;
            done          <= done_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        dir_d       = dir_q;
        start_d     = start_q;
        stop_d      = stop_q;
        step_d      = step_q;
        reload_d    = reload_q;
        cnt_d       = cnt_q;
        repeat_d    = repeat_q;
        wrap_d      = wrap_q;
        inc_d       = dds_phase_inc;
        inc_valid_d = 1'b0;
        busy_d      = busy;
        done_d      = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (start && !abort) begin
                    start_d     = cfg_start_inc;
                    stop_d      = cfg_stop_inc;
                    step_d      = cfg_step;
                    repeat_d    = cfg_repeat;
                    dir_d       = (cfg_stop_inc >= cfg_start_inc) ? UP : DOWN;
                    reload_d    = (cfg_dwell == '0) ? '0 : cfg_dwell - DWELL_W'(1);
                    cnt_d       = (cfg_dwell == '0) ? '0 : cfg_dwell - DWELL_W'(1);
                    wrap_d      = 1'b0;
                    inc_d       = cfg_start_inc;
                    inc_valid_d = 1'b1;
                    busy_d      = 1'b1;
                    state_d     = DWELL;
                end
            end
            DWELL: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - DWELL_W'(1);
                end else if ((dds_phase_inc == stop_q) && !repeat_q) begin
                    state_d = FINISH;
                end else begin
                    wrap_d  = (dds_phase_inc == stop_q);
                    state_d = STEP;
                end
            end
            STEP: begin
                // A repeat onto an unchanged value (start == stop) is not a new value.
                inc_d       = step_val_c;
                inc_valid_d = (step_val_c != dds_phase_inc);
                cnt_d       = reload_q;
                wrap_d      = 1'b0;
                state_d     = DWELL;
            end
            FINISH: begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Abort beats everything outside IDLE and freezes the output value.
        if (abort && (state_q != IDLE)) begin
            state_d     = IDLE;
            inc_d       = dds_phase_inc;
            inc_valid_d = 1'b0;
            busy_d      = 1'b0;
            done_d      = 1'b0;
            wrap_d      = 1'b0;
        end
    end

endmodule

// File: tb/tb_iq_freq_sweep_ctrl.sv
// Directed self-checking bench for iq_freq_sweep_ctrl: sweep shapes, clamping,
// repeat/abort, dwell edge cases, reset and start/abort handshakes.
module tb_iq_freq_sweep_ctrl;

    localparam int unsigned PW = 16;
    localparam int unsigned DW = 24;

    logic          clock = 1'b0;
    logic          reset;
    logic [PW-1:0] cfg_start_inc, cfg_stop_inc, cfg_step;
    logic [DW-1:0] cfg_dwell;
    logic          cfg_repeat, start, abort;
    logic [PW-1:0] dds_phase_inc;
    logic          inc_valid, busy, done;

    int n_checks = 0;
    int n_fail   = 0;

    logic [PW-1:0] vals[$];
    int            idxs[$];
    int            done_idx;
    int            busy_cnt;
    logic [PW-1:0] exp_v [5];
    int            exp_i [5];
    int            seen_done, seen_valid;

    iq_freq_sweep_ctrl dut (
        .clock         (clock),
        .reset         (reset),
        .cfg_start_inc (cfg_start_inc),
        .cfg_stop_inc  (cfg_stop_inc),
        .cfg_step      (cfg_step),
        .cfg_dwell     (cfg_dwell),
        .cfg_repeat    (cfg_repeat),
        .start         (start),
        .abort         (abort),
        .dds_phase_inc (dds_phase_inc),
        .inc_valid     (inc_valid),
        .busy          (busy),
        .done          (done)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] expv);
        n_checks++;
        assert (got === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, expv);
        end
    endtask

    task automatic pulse_start(input logic [PW-1:0] s, input logic [PW-1:0] e,
                               input logic [PW-1:0] st, input logic [DW-1:0] dw,
                               input logic rp);
        cfg_start_inc = s;
        cfg_stop_inc  = e;
        cfg_step      = st;
        cfg_dwell     = dw;
        cfg_repeat    = rp;
        start         = 1'b1;
        tick();
        start         = 1'b0;
    endtask

    // Observe from the cycle right after the start edge (index 0); optional mid-sweep start.
    task automatic collect(input int max_cycles, input int inject_at);
        vals.delete();
        idxs.delete();
        done_idx = -1;
        busy_cnt = 0;
        for (int i = 0; i < max_cycles; i++) begin
            if (inc_valid) begin
                vals.push_back(dds_phase_inc);
                idxs.push_back(i);
            end
            if (busy) busy_cnt++;
            if (done) begin
                done_idx = i;
                break;
            end
            if (i == max_cycles - 1) break;
            if (i == inject_at) begin
                start         = 1'b1;
                cfg_start_inc = 16'd500;
                cfg_stop_inc  = 16'd900;
            end
            tick();
            start = 1'b0;
        end
    endtask

    task automatic check_seq(input string tag, input int n, input int edone);
        chk($sformatf("%s_count", tag), 32'(vals.size()), 32'(n));
        for (int k = 0; k < n && k < vals.size(); k++) begin
            chk($sformatf("%s_val%0d", tag, k), 32'(vals[k]), 32'(exp_v[k]));
            chk($sformatf("%s_idx%0d", tag, k), 32'(idxs[k]), 32'(exp_i[k]));
        end
        chk($sformatf("%s_done_idx", tag), 32'(done_idx), 32'(edone));
        if (edone >= 0) begin
            chk($sformatf("%s_busy_cycles", tag), 32'(busy_cnt), 32'(edone));
            tick();
            chk($sformatf("%s_done_width", tag), 32'(done), 32'(0));
        end
    endtask

    initial begin
        reset         = 1'b1;
        cfg_start_inc = '0;
        cfg_stop_inc  = '0;
        cfg_step      = '0;
        cfg_dwell     = '0;
        cfg_repeat    = 1'b0;
        start         = 1'b0;
        abort         = 1'b0;
        tick();
        tick();
        chk("rst_inc", 32'(dds_phase_inc), 32'(0));
        chk("rst_valid", 32'(inc_valid), 32'(0));
        chk("rst_busy", 32'(busy), 32'(0));
        chk("rst_done", 32'(done), 32'(0));
        reset = 1'b0;
        tick();

        // Basic up sweep 100..130 step 10, dwell 3.
        pulse_start(16'd100, 16'd130, 16'd10, 24'd3, 1'b0);
        exp_v = '{16'd100, 16'd110, 16'd120, 16'd130, 16'd0};
        exp_i = '{0, 4, 8, 12, 0};
        collect(40, -1);
        check_seq("up", 4, 16);
        chk("up_hold_last", 32'(dds_phase_inc), 32'(130));

        // Down sweep with clamp to 0x10.
        pulse_start(16'h0050, 16'h0010, 16'h0030, 24'd2, 1'b0);
        exp_v = '{16'h0050, 16'h0020, 16'h0010, 16'h0, 16'h0};
        exp_i = '{0, 3, 6, 0, 0};
        collect(40, -1);
        check_seq("down", 3, 9);

        // Overflow clamp near full scale.
        pulse_start(16'hFFF0, 16'hFFFF, 16'h0020, 24'd1, 1'b0);
        exp_v = '{16'hFFF0, 16'hFFFF, 16'h0, 16'h0, 16'h0};
        exp_i = '{0, 2, 0, 0, 0};
        collect(40, -1);
        check_seq("ovf", 2, 4);

        // Zero step jumps to stop.
        pulse_start(16'd5, 16'd50, 16'd0, 24'd1, 1'b0);
        exp_v = '{16'd5, 16'd50, 16'd0, 16'd0, 16'd0};
        exp_i = '{0, 2, 0, 0, 0};
        collect(40, -1);
        check_seq("step0", 2, 4);

        // Dwell 0 behaves as dwell 1.
        pulse_start(16'd5, 16'd50, 16'd0, 24'd0, 1'b0);
        collect(40, -1);
        check_seq("dwell0", 2, 4);

        // start == stop, single pass.
        pulse_start(16'd77, 16'd77, 16'd3, 24'd2, 1'b0);
        exp_v = '{16'd77, 16'd0, 16'd0, 16'd0, 16'd0};
        exp_i = '{0, 0, 0, 0, 0};
        collect(40, -1);
        check_seq("eq", 1, 3);

        // Repeat 0,10,20,0,10 then abort while holding 10.
        pulse_start(16'd0, 16'd20, 16'd10, 24'd1, 1'b1);
        exp_v = '{16'd0, 16'd10, 16'd20, 16'd0, 16'd10};
        exp_i = '{0, 2, 4, 6, 8};
        collect(9, -1);
        check_seq("rep", 5, -1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort_busy", 32'(busy), 32'(0));
        chk("abort_inc", 32'(dds_phase_inc), 32'(10));
        chk("abort_valid", 32'(inc_valid), 32'(0));
        chk("abort_done", 32'(done), 32'(0));
        seen_done  = 0;
        seen_valid = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (done) seen_done++;
            if (inc_valid) seen_valid++;
        end
        chk("abort_after_done", 32'(seen_done), 32'(0));
        chk("abort_after_valid", 32'(seen_valid), 32'(0));
        chk("abort_after_inc", 32'(dds_phase_inc), 32'(10));

        // Asynchronous reset in the middle of a sweep.
        pulse_start(16'd100, 16'd130, 16'd10, 24'd3, 1'b0);
        for (int i = 0; i < 4; i++) tick();
        chk("mid_busy_pre", 32'(busy), 32'(1));
        #2 reset = 1'b1;
        #1;
        chk("arst_inc", 32'(dds_phase_inc), 32'(0));
        chk("arst_busy", 32'(busy), 32'(0));
        chk("arst_valid", 32'(inc_valid), 32'(0));
        chk("arst_done", 32'(done), 32'(0));
        tick();
        reset = 1'b0;
        tick();

        // start together with abort in IDLE does nothing.
        cfg_start_inc = 16'd300;
        cfg_stop_inc  = 16'd400;
        cfg_step      = 16'd50;
        cfg_dwell     = 24'd1;
        cfg_repeat    = 1'b0;
        start         = 1'b1;
        abort         = 1'b1;
        tick();
        start         = 1'b0;
        abort         = 1'b0;
        chk("sa_busy", 32'(busy), 32'(0));
        chk("sa_valid", 32'(inc_valid), 32'(0));
        chk("sa_inc", 32'(dds_phase_inc), 32'(0));
        tick();
        tick();
        chk("sa_busy_later", 32'(busy), 32'(0));

        // start while busy (with new cfg) leaves the sweep unchanged.
        pulse_start(16'd100, 16'd130, 16'd10, 24'd3, 1'b0);
        exp_v = '{16'd100, 16'd110, 16'd120, 16'd130, 16'd0};
        exp_i = '{0, 4, 8, 12, 0};
        collect(40, 2);
        check_seq("busy_start", 4, 16);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
